// File: rtl/axis_coef_pipeline.sv
// Multi-lane AXI-Stream "add coefficient" pipeline with AXI4-Lite registers.
// Optional AXIS_TLAST_EN adds tlast pass-through and a PKTS counter at 0x14.
module axis_coef_pipeline #(
  parameter int          DATA_W    = 16,
  parameter int          LANES     = 1,
  parameter logic [31:0] ID_VALUE  = 32'hC0EF0002,
  parameter logic [31:0] VER_VALUE = 32'h00020000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4:0]              s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [4:0]              s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
`ifdef AXIS_TLAST_EN
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tlast,
`endif
  input  logic [DATA_W*LANES-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_W*LANES-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int TW = DATA_W * LANES;

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} st_t;

  st_t               r_st, w_st_nxt;
  logic              r_run;
  logic              w_wr, w_rd;
  logic [DATA_W-1:0] r_coef;
  logic              r_sat;
  logic [31:0]       r_stats, r_rdata, w_rmux, w_cnew;
  logic              w_wcoef, w_wctrl, w_clr;

  logic              r_v1, r_v2, r_s1;
  logic [TW-1:0]     r_d1, r_d2, w_res;
  logic [DATA_W-1:0] r_c1;
  logic [DATA_W:0]   w_sum;
  logic              w_adv2, w_mv12, w_ld1, w_shs, w_ohs;
  logic              w_unused;

  // Holds every ready low until the first clock after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_run <= 1'b0;
    else          r_run <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_st <= IDLE;
    else          r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    w_wr     = 1'b0;
    w_rd     = 1'b0;
    unique case (r_st)
      IDLE: begin
        if (r_run && s_axi_awvalid && s_axi_wvalid) begin
          w_wr     = 1'b1;
          w_st_nxt = WRESP;
        end else if (r_run && s_axi_arvalid) begin
          w_rd     = 1'b1;
          w_st_nxt = RRESP;
        end
      end
      WRESP: if (s_axi_bready) w_st_nxt = IDLE;
      RRESP: if (s_axi_rready) w_st_nxt = IDLE;
      default: w_st_nxt = IDLE;
    endcase
  end

  assign s_axi_awready = w_wr;
  assign s_axi_wready  = w_wr;
  assign s_axi_arready = w_rd;
  assign s_axi_bvalid  = (r_st == WRESP);
  assign s_axi_rvalid  = (r_st == RRESP);
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rdata   = r_rdata;

  assign w_wcoef = w_wr && (s_axi_awaddr[4:2] == 3'd3);
  assign w_wctrl = w_wr && (s_axi_awaddr[4:2] == 3'd4);
  assign w_clr   = w_wctrl && s_axi_wstrb[0] && s_axi_wdata[1];

  always_comb begin
    w_cnew = 32'(r_coef);
    for (int b = 0; b < 4; b++)
      if (s_axi_wstrb[b]) w_cnew[8*b +: 8] = s_axi_wdata[8*b +: 8];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_coef <= '0;
      r_sat  <= 1'b0;
    end else begin
      if (w_wcoef) r_coef <= w_cnew[DATA_W-1:0];
      if (w_wctrl && s_axi_wstrb[0]) r_sat <= s_axi_wdata[0];
    end
  end

`ifdef AXIS_TLAST_EN
  logic [31:0] r_pkts;
  logic        r_l1, r_l2;
`endif

  always_comb begin
    w_rmux = '0;
    case (s_axi_araddr[4:2])
      3'd0: w_rmux = ID_VALUE;
      3'd1: w_rmux = VER_VALUE;
      3'd2: w_rmux = r_stats;
      3'd3: w_rmux = 32'(r_coef);
      3'd4: w_rmux = {31'd0, r_sat};
`ifdef AXIS_TLAST_EN
      3'd5: w_rmux = r_pkts;
`endif
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rmux;
  end

  assign w_adv2        = !r_v2 || m_axis_tready;
  assign w_mv12        = r_v1 && w_adv2;
  assign w_ld1         = !r_v1 || w_mv12;
  assign s_axis_tready = r_run && w_ld1;
  assign w_shs         = s_axis_tvalid && s_axis_tready;
  assign w_ohs         = r_v2 && m_axis_tready;

  always_comb begin
    w_res = '0;
    w_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sum = {1'b0, r_d1[k*DATA_W +: DATA_W]} + {1'b0, r_c1};
      w_res[k*DATA_W +: DATA_W] = (r_s1 && w_sum[DATA_W]) ?
        {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
    end
  end

  // Coefficient and mode are snapshotted with each beat at S1 capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
      r_c1 <= '0;
      r_s1 <= 1'b0;
      r_v2 <= 1'b0;
      r_d2 <= '0;
    end else begin
      if (w_ld1) begin
        r_v1 <= w_shs;
        if (w_shs) begin
          r_d1 <= s_axis_tdata;
          r_c1 <= r_coef;
          r_s1 <= r_sat;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= w_res;
      end
    end
  end

  assign m_axis_tdata  = r_d2;
  assign m_axis_tvalid = r_v2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   r_stats <= '0;
    else if (w_clr) r_stats <= '0;
    else if (w_ohs) r_stats <= r_stats + 32'd1;
  end

`ifdef AXIS_TLAST_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_l1   <= 1'b0;
      r_l2   <= 1'b0;
      r_pkts <= '0;
    end else begin
      if (w_ld1 && w_shs) r_l1 <= s_axis_tlast;
      if (w_adv2 && r_v1) r_l2 <= r_l1;
      if (w_clr)                r_pkts <= '0;
      else if (w_ohs && r_l2)   r_pkts <= r_pkts + 32'd1;
    end
  end

  assign m_axis_tlast = r_l2;
`endif

  assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], w_cnew};

endmodule

// File: tb/tb_axis_coef_pipeline.sv
// Directed bench for axis_coef_pipeline, 4 lanes of 16 bits.
// Vector tables plus hand sequences for stalls, in-flight COEF and reset.
module tb_axis_coef_pipeline;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int TW = DW * LN;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    awaddr = '0, araddr = '0;
  logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [TW-1:0] s_tdata = '0, m_tdata;
  logic          s_tvalid = 0, s_tready, m_tvalid, m_tready = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  logic [TW-1:0] tx_q[$], rx_q[$], ex_q[$];

  typedef struct {
    logic [TW-1:0] din;
    logic [TW-1:0] dexp;
  } vec_t;

  vec_t vw[7];
  vec_t vs[4];

  always #5 clock = ~clock;

  axis_coef_pipeline #(.DATA_W(DW), .LANES(LN)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    @(negedge clock);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clock); #1; n++; end
    if (!awready || !wready) tmo("aw_w_handshake");
    @(negedge clock);
    awvalid = 0; wvalid = 0; bready = 1;
    #1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clock); #1; n++; end
    if (!bvalid) tmo("b_handshake");
    else chk("bresp", 64'(bresp), 64'd0);
    @(negedge clock);
    bready = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] r);
    int n;
    d = '0;
    r = 2'b11;
    @(negedge clock);
    araddr = a; arvalid = 1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clock); #1; n++; end
    if (!arready) tmo("ar_handshake");
    @(negedge clock);
    arvalid = 0; rready = 1;
    #1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clock); #1; n++; end
    if (!rvalid) tmo("r_handshake");
    else begin d = rdata; r = rresp; end
    @(negedge clock);
    rready = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk(nm, 64'(d), 64'(exp));
    chk({nm, "_rresp"}, 64'(r), 64'd0);
  endtask

  // One loop iteration per cycle; handshakes evaluated 1 time unit after
  // the falling edge, i.e. before the rising edge that completes them.
  task automatic run_stream(input bit pat, input bit gaps, output int cyc);
    int          idx;
    bit          held, stall;
    logic [TW-1:0] saved;
    idx = 0; held = 0; stall = 0; saved = '0; cyc = 0;
    rx_q.delete();
    while ((idx < tx_q.size() || rx_q.size() < tx_q.size()) && cyc < 5000) begin
      @(negedge clock);
      cyc++;
      if (!held) s_tvalid = 0;
      if (!held && idx < tx_q.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
        s_tdata = tx_q[idx];
        s_tvalid = 1;
        held = 1;
      end
      m_tready = pat ? (cyc % 3 == 1) : 1'b1;
      #1;
      if (stall) begin
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_data", m_tdata, saved);
      end
      if (s_tvalid && s_tready) begin idx++; held = 0; end
      if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
      stall = m_tvalid && !m_tready;
      saved = m_tdata;
    end
    @(negedge clock);
    s_tvalid = 0;
    m_tready = 1;
    if (cyc >= 5000) tmo("stream");
  endtask

  initial begin
    int          cyc;
    logic [31:0] d;
    logic [1:0]  r;
    logic [TW-1:0] t, e;

    vw[0] = '{{16'hFFFF, 16'h0000, 16'h1234, 16'd0},
              {16'h0000, 16'h0001, 16'h1235, 16'd1}};
    vw[1] = '{{16'h0001, 16'hFFFE, 16'h7FFF, 16'd1},
              {16'h0002, 16'hFFFF, 16'h8000, 16'd2}};
    vw[2] = '{{16'h0002, 16'h0002, 16'h0002, 16'd2},
              {16'h0003, 16'h0003, 16'h0003, 16'd3}};
    vw[3] = '{{16'h8000, 16'h00FF, 16'hFFFF, 16'd99},
              {16'h8001, 16'h0100, 16'h0000, 16'd100}};
    vw[4] = '{{16'd100, 16'd200, 16'd300, 16'd100},
              {16'd101, 16'd201, 16'd301, 16'd101}};
    vw[5] = '{{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'd65534},
              {16'h0000, 16'hFFFF, 16'hFFFE, 16'd65535}};
    vw[6] = '{{16'h0000, 16'h0000, 16'hFFFF, 16'd65535},
              {16'h0001, 16'h0001, 16'h0000, 16'd0}};

    vs[0] = '{{16'h0000, 16'hFFF0, 16'h8000, 16'd65533},
              {16'h0002, 16'hFFF2, 16'h8002, 16'd65535}};
    vs[1] = '{{16'hFFFF, 16'h7FFF, 16'h0001, 16'd65534},
              {16'hFFFF, 16'h8001, 16'h0003, 16'd65535}};
    vs[2] = '{{16'hFFFE, 16'hFFFD, 16'hFFFC, 16'd65535},
              {16'hFFFF, 16'hFFFF, 16'hFFFE, 16'd65535}};
    vs[3] = '{{16'h0007, 16'hFFFF, 16'h1000, 16'd7},
              {16'h0009, 16'hFFFF, 16'h1002, 16'd9}};

    // Reset state, with requests already raised
    awvalid = 1; wvalid = 1; arvalid = 1;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clock);
    reset_n = 1;
    repeat (2) @(negedge clock);

    rd_chk("id", 5'h00, 32'hC0EF0002);
    rd_chk("ver", 5'h04, 32'h00020000);
    rd_chk("stats0", 5'h08, 32'd0);
    rd_chk("coef0", 5'h0C, 32'd0);
    rd_chk("ctrl0", 5'h10, 32'd0);
    rd_chk("pkts_absent", 5'h14, 32'd0);

    // Wrapping add, COEF=1, tready always high
    axi_write(5'h0C, 32'd1, 4'hF);
    axi_write(5'h10, 32'd0, 4'hF);
    tx_q.delete();
    foreach (vw[i]) tx_q.push_back(vw[i].din);
    run_stream(1'b0, 1'b0, cyc);
    chk("wrap_count", 64'(rx_q.size()), 64'd7);
    chk("wrap_latency", 64'(cyc), 64'd9);
    for (int i = 0; i < 7; i++)
      if (i < rx_q.size()) chk("wrap_vec", rx_q[i], vw[i].dexp);
    rd_chk("stats7", 5'h08, 32'd7);

    // Saturating add, COEF=2
    axi_write(5'h10, 32'd1, 4'hF);
    axi_write(5'h0C, 32'd2, 4'hF);
    rd_chk("ctrl_sat", 5'h10, 32'd1);
    tx_q.delete();
    foreach (vs[i]) tx_q.push_back(vs[i].din);
    run_stream(1'b0, 1'b0, cyc);
    chk("sat_count", 64'(rx_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) chk("sat_vec", rx_q[i], vs[i].dexp);
    rd_chk("stats11", 5'h08, 32'd11);

    // CLR_STATS pulse, SAT cleared by the same write
    axi_write(5'h10, 32'd2, 4'hF);
    rd_chk("stats_clr", 5'h08, 32'd0);
    rd_chk("ctrl_clr", 5'h10, 32'd0);

    // Byte strobes on COEF
    axi_write(5'h0C, 32'h0000ABCD, 4'b0001);
    rd_chk("coef_strb", 5'h0C, 32'h000000CD);
    axi_write(5'h0C, 32'h12340001, 4'hF);
    rd_chk("coef_trunc", 5'h0C, 32'd1);

    // 200 random beats, ready pattern 1,0,0 and random valid gaps
    tx_q.delete();
    ex_q.delete();
    for (int i = 0; i < 200; i++) begin
      t = {$urandom, $urandom};
      for (int k = 0; k < LN; k++) e[k*DW +: DW] = t[k*DW +: DW] + 16'd1;
      tx_q.push_back(t);
      ex_q.push_back(e);
    end
    run_stream(1'b1, 1'b1, cyc);
    chk("rand_count", 64'(rx_q.size()), 64'd200);
    for (int i = 0; i < 200; i++)
      if (i < rx_q.size()) chk("rand_beat", rx_q[i], ex_q[i]);
    rd_chk("stats200", 5'h08, 32'd200);

    // Unmapped and read-only addresses
    rd_chk("unmapped", 5'h1C, 32'd0);
    axi_write(5'h00, 32'hFFFFFFFF, 4'hF);
    rd_chk("id_ro", 5'h00, 32'hC0EF0002);
    axi_write(5'h08, 32'h55555555, 4'hF);
    rd_chk("stats_ro", 5'h08, 32'd200);

    // COEF change with two beats parked in the pipeline
    @(negedge clock);
    m_tready = 0;
    s_tdata = {4{16'h0010}};
    s_tvalid = 1;
    @(negedge clock);
    s_tdata = {4{16'hFFFF}};
    @(negedge clock);
    s_tvalid = 0;
    #1;
    chk("park_full", 64'(s_tready), 64'd0);
    axi_write(5'h0C, 32'd3, 4'hF);
    @(negedge clock);
    m_tready = 1;
    #1;
    chk("inflight_a", m_tdata, {4{16'h0011}});
    chk("inflight_a_v", 64'(m_tvalid), 64'd1);
    @(negedge clock);
    #1;
    chk("inflight_b", m_tdata, {4{16'h0000}});
    tx_q.delete();
    tx_q.push_back({4{16'h0100}});
    run_stream(1'b0, 1'b0, cyc);
    chk("newcoef_count", 64'(rx_q.size()), 64'd1);
    if (rx_q.size() > 0) chk("newcoef_beat", rx_q[0], {4{16'h0103}});

    // Reset with two beats in flight
    @(negedge clock);
    m_tready = 0;
    s_tdata = {4{16'h0020}};
    s_tvalid = 1;
    @(negedge clock);
    s_tdata = {4{16'h0030}};
    @(negedge clock);
    s_tvalid = 0;
    #1;
    chk("pre_rst_valid", 64'(m_tvalid), 64'd1);
    reset_n = 0;
    #1;
    chk("rst_mid_valid", 64'(m_tvalid), 64'd0);
    chk("rst_mid_ready", 64'(s_tready), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    m_tready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("post_rst_valid", 64'(m_tvalid), 64'd0);
    end
    rd_chk("post_rst_coef", 5'h0C, 32'd0);
    rd_chk("post_rst_stats", 5'h08, 32'd0);
    tx_q.delete();
    tx_q.push_back(64'h1111_2222_3333_FFFF);
    run_stream(1'b0, 1'b0, cyc);
    chk("post_rst_count", 64'(rx_q.size()), 64'd1);
    if (rx_q.size() > 0) chk("post_rst_beat", rx_q[0], 64'h1111_2222_3333_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_coef_pipeline.md
Name: axis_coef_pipeline

Overview:
Parametrised successor to the single-lane AXI-Stream "add coefficient" pipeline. It has an AXI4-Lite register slave and LANES parallel DATA_W-bit lanes per beat. Each lane computes out = in + COEF, either wrapping or saturating (selected by register). It sits between an AXI-Stream master and slave in the Vivado block design, with full tready backpressure and a sample counter readable over AXI-Lite.

Parameters:
DATA_W, 16, width of one lane in bits (2..32)
LANES, 1, number of lanes packed in tdata (1..8)
ID_VALUE, 32'hC0EF0002, value returned by the ID register
VER_VALUE, 32'h00020000, value returned by the VER register

Ports:
clock  in  1  single clock for all interfaces
reset_n  in  1  asynchronous, active-low reset
s_axi_awaddr  in  5  write address (byte)
s_axi_awvalid / s_axi_awready  in/out  1  write address handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  write byte strobes
s_axi_wvalid / s_axi_wready  in/out  1  write data handshake
s_axi_bresp  out  2  always 2'b00 (OKAY)
s_axi_bvalid / s_axi_bready  out/in  1  write response handshake
s_axi_araddr  in  5  read address
s_axi_arvalid / s_axi_arready  in/out  1  read address handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00
s_axi_rvalid / s_axi_rready  out/in  1  read data handshake
s_axis_tdata  in  DATA_W*LANES  input samples (lane k at bits [k*DATA_W +: DATA_W])
s_axis_tvalid / s_axis_tready  in/out  1  input handshake
m_axis_tdata  out  DATA_W*LANES  output samples
m_axis_tvalid / m_axis_tready  out/in  1  output handshake

Behaviour:
- Reset (async assert, sync release): all valid/ready outputs 0; rdata 0; COEF 0; CTRL 0; STATS 0; pipeline emptied.
- Register map (address bits [4:2]):
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x04 VER: RO, returns VER_VALUE.
  - 0x08 STATS: RO, 32-bit count of m_axis handshakes; wraps 0xFFFFFFFF->0.
  - 0x0C COEF: RW, DATA_W bits, zero-extended on read.
  - 0x10 CTRL: bit0 SAT (RW); bit1 CLR_STATS (write-1 pulse, reads 0).
  - Other addresses: read 0 with OKAY; writes ignored. Writes to RO registers are ignored.
- wstrb applies per byte to COEF and CTRL.
- AXI-Lite FSM has states IDLE, WRESP, RRESP.
  - IDLE: when awvalid and wvalid are both high, assert awready and wready for one cycle, commit the write, go to WRESP.
  - Otherwise, if arvalid is high, assert arready for one cycle, register rdata, go to RRESP.
  - A write takes priority over a simultaneous read.
  - WRESP: bvalid=1 until bready, then IDLE. RRESP: rvalid=1 and rdata held until rready, then IDLE.
  - One transaction outstanding at a time.
- Datapath: two register stages (S1 captures input and COEF snapshot; S2 holds result). Latency 2 cycles from s_axis handshake to m_axis_tvalid when unstalled.
  - Stage advance: S2 loads when empty or m_axis_tready=1; S1 loads when empty or S1 is moving to S2.
  - s_axis_tready = !v1 || !v2 || m_axis_tready (combinational, no bubble).
  - Throughput: 1 beat/cycle with tready held high.
  - m_axis_tdata and tvalid stay stable while tvalid=1 and tready=0.
- Arithmetic per lane: sum = {1'b0,in} + {1'b0,COEF} (DATA_W+1 bits).
  - SAT=0: out = sum[DATA_W-1:0] (wraps).
  - SAT=1: out = all-ones if sum[DATA_W] else sum[DATA_W-1:0].
- COEF/SAT are sampled at S1 capture. A write commits on its aw/w handshake cycle and applies to beats captured on later cycles. Beats already in flight keep their old values.
- CLR_STATS in the same cycle as an output handshake: STATS becomes 0.
- Reset mid-stream: in-flight beats are dropped, no partial output. AXI-Lite transactions are abandoned.

Optional Feature:
AXIS_TLAST_EN: when defined, the block adds ports s_axis_tlast/m_axis_tlast, carried through both stages aligned with data. It also adds register 0x14 PKTS (RO, 32-bit count of output beats with tlast=1, wraps, cleared by CLR_STATS). When not defined, there are no tlast ports, and 0x14 reads 0.

Test Plan:
- After reset, read 0x00/0x04/0x08/0x0C/0x10 -> 0xC0EF0002, 0x00020000, 0, 0, 0; all rresp OKAY.
- Write COEF=1, SAT=0; send {0,1,2,99,100,65534,65535} -> receive {1,2,3,100,101,65535,0} in order; STATS reads 7.
- Write CTRL=1, COEF=2; send {65533,65534,65535,7} -> receive {65535,65535,65535,9}.
- LANES=4, COEF=1; send 200 random beats with m_axis_tready pattern 1,0,0 repeating and random s_axis_tvalid gaps -> no loss/duplication, order kept, stall data stable, STATS=200.
- Write CTRL=2 -> STATS reads 0 and CTRL reads 0; read 0x1C -> 0 OKAY; write 0x00=0xFFFFFFFF -> ID unchanged.
- Assert reset_n low with 2 beats in flight -> m_axis_tvalid=0 within the reset; after release, COEF=0 and the next beat x returns x.
